// File: rtl/gb_pixel_feeder.sv
// Raster-order frame source for the Gaussian-blur stencil: reads a synchronous-read
// pixel memory and streams one 8-bit pixel per cycle on an AXI-stream style output.
module gb_pixel_feeder #(
  parameter int IMG_W = 648,
  parameter int IMG_H = 488,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    arg_1_TDATA,
  output logic          arg_1_TVALID,
  input  logic          arg_1_TREADY
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] rd_cnt, tx_cnt;
  logic          inflight;
  logic [1:0]    fcount;
  logic [7:0]    tail;
  logic [AW-1:0] addr_q;
  logic          pop, push, issue, last_beat;

  // arg_1_TDATA is the FIFO head register itself, so it never sees mem_rdata combinationally.
  assign arg_1_TVALID = (fcount != 2'd0);
  assign pop          = arg_1_TVALID && arg_1_TREADY;
  assign push         = inflight;
  assign last_beat    = (state == RUN) && pop && (tx_cnt == CW'(NPIX - 1));
  assign issue        = (state == RUN) && !abort && (rd_cnt < CW'(NPIX)) &&
                        (((3'(fcount) + 3'(inflight)) < 3'd2) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !abort) state_nxt = RUN;
      RUN:  if (abort || last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    mem_rd   = issue;
    mem_addr = issue ? AW'(rd_cnt) : addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      inflight    <= 1'b0;
      fcount      <= 2'd0;
      tail        <= 8'd0;
      arg_1_TDATA <= 8'd0;
      addr_q      <= '0;
      done        <= 1'b0;
    end else begin
      done <= last_beat && !abort;
      if (issue) addr_q <= AW'(rd_cnt);
      if (abort || last_beat) begin
        // Abort drops the FIFO and any read still in flight; frame end just rewinds.
        rd_cnt   <= '0;
        tx_cnt   <= '0;
        inflight <= 1'b0;
        fcount   <= 2'd0;
      end else begin
        inflight <= issue;
        if (issue) rd_cnt <= rd_cnt + CW'(1);
        if (pop)   tx_cnt <= tx_cnt + CW'(1);
        unique case ({push, pop})
          2'b10: begin
            if (fcount == 2'd0) arg_1_TDATA <= mem_rdata;
            else                tail        <= mem_rdata;
            fcount <= fcount + 2'd1;
          end
          2'b01: begin
            if (fcount == 2'd2) arg_1_TDATA <= tail;
            fcount <= fcount - 2'd1;
          end
          2'b11: begin
            if (fcount == 2'd1) arg_1_TDATA <= mem_rdata;
            else begin
              arg_1_TDATA <= tail;
              tail        <= mem_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
